// File: rtl/rv_imem_responder.sv
`default_nettype none
// ============================================================================
// rv_imem_responder : in-order, fixed-latency instruction memory responder
//                     with a write-only preload port.            Rev 1.0
// ============================================================================
module rv_imem_responder #(
  parameter int BIN_DIG         = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BIN_DIG-1:0] req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BIN_DIG-1:0] rsp_data,
  output logic               rsp_err,
  input  logic               load_en,
  input  logic [BIN_DIG-1:0] load_addr,
  input  logic [BIN_DIG-1:0] load_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [BIN_DIG-3:0] DEPTH_LIM = (BIN_DIG-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);

  logic [BIN_DIG-1:0]         mem [DEPTH_WORDS];
  logic [BIN_DIG-3:0]         req_word;
  logic [BIN_DIG-3:0]         load_word;
  logic                       req_err;
  logic                       accept;
  logic                       pop;
  logic                       push;
  logic                       fifo_full;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           fifo_cnt;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [LATENCY-1:0]         pipe_valid;
  logic [LATENCY-1:0]         pipe_err;
  logic [BIN_DIG-1:0]         pipe_data [LATENCY];
  logic [BIN_DIG-1:0]         fifo_data [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_err;
  logic                       unused_load_lsbs;

  assign req_word         = req_addr[BIN_DIG-1:2];
  assign load_word        = load_addr[BIN_DIG-1:2];
  assign unused_load_lsbs = ^load_addr[1:0];
  assign req_err          = (req_addr[1:0] != 2'b00) || (req_word >= DEPTH_LIM);

  // Credit comes only from the registered count, so a pop frees a slot one cycle later.
  assign req_ready = (count < MAX_CNT);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pipe_valid[LATENCY-1];
  assign fifo_full = (fifo_cnt == MAX_CNT);
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (load_en && (load_word < DEPTH_LIM)) begin
      mem[load_word[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept && req_err;
      pipe_data[0]  <= (accept && !req_err) ? mem[req_word[IDX_W-1:0]] : '0;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_err[s]   <= pipe_err[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
      fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count    <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      count    <= count + CNT_W'(accept) - CNT_W'(pop);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  a_count_max : assert property (@(posedge CLK) disable iff (RST) count <= MAX_CNT);
  a_no_ovf    : assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full && !pop));
  a_hold      : assert property (@(posedge CLK) disable iff (RST)
                  (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_err)));

endmodule
`default_nettype wire

// File: tb/tb_rv_imem_responder.sv
`default_nettype none
// ============================================================================
// tb_rv_imem_responder : randomized + directed bench with a transaction-level
//                        reference model per DUT configuration.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rv_imem_responder;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int NI    = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] due;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        rdy  [NI];
  logic        vld  [NI];
  logic [31:0] dat  [NI];
  logic        erro [NI];

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  logic [32:0] got0 [$];
  logic [32:0] got1 [$];
  logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%09h expected 0x%09h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance 0: LATENCY 1 / 2 outstanding, 1: LATENCY 3 / 2, 2: LATENCY 1 / 3.
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int LAT  = (gi == 1) ? 3 : 1;
    localparam int MAXO = (gi == 2) ? 3 : 2;

    ent_t        fly  [$];
    ent_t        done [$];
    logic [31:0] mm [DEPTH];
    int unsigned cyc = 0;

    rv_imem_responder #(
      .BIN_DIG(W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(rdy[gi]), .req_addr(req_addr),
      .rsp_valid(vld[gi]), .rsp_ready(rsp_ready), .rsp_data(dat[gi]), .rsp_err(erro[gi]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always @(posedge CLK) begin : mdl
      bit   acc;
      ent_t e;
      cyc++;
      if (RST) begin
        fly.delete();
        done.delete();
      end else begin
        acc = req_valid && ((fly.size() + done.size()) < MAXO);
        if (done.size() != 0 && rsp_ready) void'(done.pop_front());
        while (fly.size() != 0 && fly[0].due == cyc) done.push_back(fly.pop_front());
        if (acc) begin
          e.err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH);
          e.data = e.err ? 32'd0 : mm[req_addr[2 +: 8]];
          e.due  = cyc + LAT;
          fly.push_back(e);
        end
      end
      if (load_en && load_addr[31:2] < DEPTH) mm[load_addr[2 +: 8]] = load_data;
    end

    always @(negedge CLK) begin
      if (started) begin
        check($sformatf("i%0d_req_ready", gi), 33'(rdy[gi]), 33'((fly.size() + done.size()) < MAXO));
        check($sformatf("i%0d_rsp_valid", gi), 33'(vld[gi]), 33'(done.size() != 0));
        check($sformatf("i%0d_rsp_err_data", gi), {erro[gi], dat[gi]},
              (done.size() != 0) ? {done[0].err, done[0].data} : 33'd0);
      end
    end
  end

  always @(negedge CLK) begin
    if (started && !RST && rsp_ready) begin
      if (vld[0]) got0.push_back({erro[0], dat[0]});
      if (vld[1]) got1.push_back({erro[1], dat[1]});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Holds the request until instance 0 takes it.
  task automatic issue(input logic [31:0] a);
    int k;
    k = 0;
    req_valid = 1'b1; req_addr = a;
    while (!rdy[0] && k < 100) begin
      step();
      k++;
    end
    check("issue_ready", 33'(rdy[0]), 33'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (got0.size() < n && k < 200) begin
      step();
      k++;
    end
    check("wait_rsp_count", 33'(got0.size()), 33'(n));
  endtask

  task automatic drain();
    repeat (8) step();
    got0.delete();
    got1.delete();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned m;
    m = $urandom_range(0, 9);
    if (m < 6)       return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
    else if (m == 6) return 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
    else if (m == 7) return 32'(DEPTH * 4);
    else if (m == 8) return 32'((DEPTH - 1) * 4);
    else             return $urandom;
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    RST = 1'b1;
    step();
    started = 1'b1;
    step();
    RST = 1'b0;
    check("rst_req_ready", 33'(rdy[0]), 33'd1);
    check("rst_rsp_valid", 33'(vld[0]), 33'd0);
    check("rst_rsp_err_data", {erro[0], dat[0]}, 33'd0);

    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom);
    for (int i = 0; i < 4; i++) load(32'(i * 4), prog[i]);

    // Single fetch, LATENCY 1
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    check("t1_not_yet_valid", 33'(vld[0]), 33'd0);
    step();
    check("t1_valid", 33'(vld[0]), 33'd1);
    check("t1_data", {erro[0], dat[0]}, {1'b0, 32'h00000013});
    drain();

    // Back-to-back stream: 3-deep instance must never stall
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      check("t2_throughput_ready", 33'(rdy[2]), 33'd1);
      step();
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) issue(32'(i * 4));
    wait_rsp(4);
    for (int i = 0; i < 4; i++) check("t2_order", got0[i], {1'b0, prog[i]});
    drain();

    // Backpressure with two outstanding
    rsp_ready = 1'b0;
    issue(32'h0);
    issue(32'h4);
    req_valid = 1'b1; req_addr = 32'h8;
    repeat (3) begin
      step();
      check("t3_stall_ready", 33'(rdy[0]), 33'd0);
      check("t3_hold_data", {erro[0], dat[0]}, {1'b0, 32'h00000013});
    end
    rsp_ready = 1'b1;
    issue(32'h8);
    wait_rsp(3);
    for (int i = 0; i < 3; i++) check("t3_order", got0[i], {1'b0, prog[i]});
    drain();

    // Misaligned / out-of-range, then a good fetch
    issue(32'h2);
    issue(32'(DEPTH * 4));
    issue(32'h4);
    wait_rsp(3);
    check("t4_misaligned", got0[0], {1'b1, 32'h0});
    check("t4_out_of_range", got0[1], {1'b1, 32'h0});
    check("t4_recover", got0[2], {1'b0, 32'h00100093});
    drain();

    // Same-edge load and fetch of one word
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    load_en = 1'b0; req_valid = 1'b0;
    issue(32'h4);
    wait_rsp(2);
    check("t5_old_value", got0[0], {1'b0, 32'h00100093});
    check("t5_new_value", got0[1], {1'b0, 32'hDEADBEEF});
    drain();

    // Reset with two requests in flight on the LATENCY 3 instance
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    check("t6_full", 33'(rdy[1]), 33'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_rst_valid", 33'(vld[1]), 33'd0);
    check("t6_rst_ready", 33'(rdy[1]), 33'd1);
    n = got1.size();
    repeat (8) step();
    check("t6_no_stale", 33'(got1.size()), 33'(n));
    req_valid = 1'b1; req_addr = 32'hC;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("t6_lat3_early", 33'(vld[1]), 33'd0);
    step();
    check("t6_lat3_valid", 33'(vld[1]), 33'd1);
    check("t6_lat3_data", {erro[1], dat[1]}, {1'b0, 32'h00308193});
    drain();

    // Randomized traffic, loads and occasional resets
    for (int c = 0; c < 3000; c++) begin
      RST       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 9) < 6);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 9) < 7);
      load_en   = ($urandom_range(0, 9) == 0);
      load_addr = 32'($urandom_range(0, (DEPTH + 8) * 4 - 1));
      load_data = $urandom;
      step();
    end
    RST = 1'b0; req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
